// File: rtl/rxd.sv
// UART frame receiver: recovers start, FRAME_WD data bits (LSB first), an optional
// parity bit and one stop bit from an asynchronous serial line. It presents the
// frame with a one-cycle rx_done strobe and parity/stop error flags.
//
// Handshake: the output side has no backpressure. rx_done is a single-cycle valid
// strobe. data_frame, parity_error and frame_error change only on the rx_done
// cycle and hold until the next one. The consumer must capture them on that
// cycle or any later one before the next strobe.
module rxd #(
  parameter int    CLK_FREQUENCE = 50_000_000,
  parameter int    BPS           = 115_200,
  parameter string PARITY_BIT    = "NONE",
  parameter int    FRAME_WD      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                uart_rx,
  output logic                rx_done,
  output logic [FRAME_WD-1:0] data_frame,
  output logic                parity_error,
  output logic                frame_error
);

  localparam int BIT_CNT = CLK_FREQUENCE / BPS;
  localparam int CNT_W   = $clog2(BIT_CNT);
  localparam int IDX_W   = (FRAME_WD > 1) ? $clog2(FRAME_WD) : 1;

  localparam logic [CNT_W-1:0] FULL_MAX = CNT_W'(BIT_CNT - 1);
  localparam logic [CNT_W-1:0] HALF_MAX = CNT_W'(BIT_CNT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_WD - 1);

  localparam bit HAS_PARITY = (PARITY_BIT != "NONE");
  localparam bit ODD_PARITY = (PARITY_BIT == "ODD");

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic                rx_meta_q, rx_sync_q, rx_dly_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [FRAME_WD-1:0] shift_q, shift_d;
  logic                par_q, par_d;
  logic [FRAME_WD-1:0] data_frame_q, data_frame_d;
  logic                parity_error_q, parity_error_d;
  logic                frame_error_q, frame_error_d;
  logic                rx_done_q, rx_done_d;

  logic fall_edge;
  logic half_tick;
  logic full_tick;

  // Start-bit edge, seen on the synchronised line against its one-cycle delay
  assign fall_edge = rx_dly_q & ~rx_sync_q;
  // Mid-start-bit strobe; only meaningful in START
  assign half_tick = (cnt_q == HALF_MAX);
  // Bit-centre strobe for DATA/PARITY/STOP, one full bit after the previous centre
  assign full_tick = (cnt_q == FULL_MAX);

  // Two-flop synchroniser plus one delay stage for edge detection; all idle high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_dly_q  <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_dly_q  <= rx_sync_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: START re-checks the line mid-bit so short glitches are dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fall_edge) state_d = START;
      end
      START: begin
        if (half_tick) state_d = rx_sync_q ? IDLE : DATA;
      end
      DATA: begin
        if (full_tick && (idx_q == IDX_LAST)) state_d = HAS_PARITY ? PARITY : STOP;
      end
      PARITY: begin
        if (full_tick) state_d = STOP;
      end
      STOP: begin
        // Leave at the stop-bit centre so the next start edge is never missed
        if (full_tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values: baud counter, bit index, shifter, result capture
  always_comb begin
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    shift_d        = shift_q;
    par_d          = par_q;
    data_frame_d   = data_frame_q;
    parity_error_d = parity_error_q;
    frame_error_d  = frame_error_q;
    rx_done_d      = 1'b0;

    // Counter restarts on every state change and on wrap; idles at zero
    if ((state_d != state_q) || (state_q == IDLE) || full_tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Bit index only advances inside DATA, otherwise parked at the first bit
    if (state_q != DATA) begin
      idx_d = '0;
    end else if (full_tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    case (state_q)
      DATA: begin
        if (full_tick) shift_d[idx_q] = rx_sync_q;
      end
      PARITY: begin
        if (full_tick) par_d = rx_sync_q;
      end
      STOP: begin
        if (full_tick) begin
          rx_done_d      = 1'b1;
          data_frame_d   = shift_q;
          frame_error_d  = ~rx_sync_q;
          parity_error_d = HAS_PARITY ? ((^shift_q) ^ par_q ^ ODD_PARITY) : 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      idx_q          <= '0;
      shift_q        <= '0;
      par_q          <= 1'b0;
      data_frame_q   <= '0;
      parity_error_q <= 1'b0;
      frame_error_q  <= 1'b0;
      rx_done_q      <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      shift_q        <= shift_d;
      par_q          <= par_d;
      data_frame_q   <= data_frame_d;
      parity_error_q <= parity_error_d;
      frame_error_q  <= frame_error_d;
      rx_done_q      <= rx_done_d;
    end
  end

  assign rx_done      = rx_done_q;
  assign data_frame   = data_frame_q;
  assign parity_error = parity_error_q;
  assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_rxd.sv
// Bench for rxd: four receivers (NONE/8, EVEN/8, NONE/6, ODD/5) on separate lines,
// directed scenarios followed by random frames, checked against a frame-level model.
module tb_rxd;

  localparam int BIT = 10;  // 50 MHz / 5 Mbaud

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] lines = 4'b1111;

  logic       done0, done1, done2, done3;
  logic [7:0] data0, data1;
  logic [5:0] data2;
  logic [4:0] data3;
  logic       pe0, pe1, pe2, pe3;
  logic       fe0, fe1, fe2, fe3;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  int wd_of [4] = '{8, 8, 6, 5};
  int pm_of [4] = '{0, 1, 0, 2};   // 0 none, 1 even, 2 odd

  // Scoreboard entries are {frame_error, parity_error, data[15:0]}
  logic [17:0] exp_q0[$], exp_q1[$], exp_q2[$], exp_q3[$];
  int          st_q0[$], st_q1[$], st_q2[$], st_q3[$];
  logic [3:0]  prev_done = 4'b0000;

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rxd #(.CLK_FREQUENCE(50_000_000), .BPS(5_000_000), .PARITY_BIT("NONE"), .FRAME_WD(8)) u_n8 (
    .clk(clk), .rst_n(rst_n), .uart_rx(lines[0]), .rx_done(done0),
    .data_frame(data0), .parity_error(pe0), .frame_error(fe0));
  rxd #(.CLK_FREQUENCE(50_000_000), .BPS(5_000_000), .PARITY_BIT("EVEN"), .FRAME_WD(8)) u_e8 (
    .clk(clk), .rst_n(rst_n), .uart_rx(lines[1]), .rx_done(done1),
    .data_frame(data1), .parity_error(pe1), .frame_error(fe1));
  rxd #(.CLK_FREQUENCE(50_000_000), .BPS(5_000_000), .PARITY_BIT("NONE"), .FRAME_WD(6)) u_n6 (
    .clk(clk), .rst_n(rst_n), .uart_rx(lines[2]), .rx_done(done2),
    .data_frame(data2), .parity_error(pe2), .frame_error(fe2));
  rxd #(.CLK_FREQUENCE(50_000_000), .BPS(5_000_000), .PARITY_BIT("ODD"), .FRAME_WD(5)) u_o5 (
    .clk(clk), .rst_n(rst_n), .uart_rx(lines[3]), .rx_done(done3),
    .data_frame(data3), .parity_error(pe3), .frame_error(fe3));

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input int idx, input logic [17:0] e, input int st);
    case (idx)
      0: begin exp_q0.push_back(e); st_q0.push_back(st); end
      1: begin exp_q1.push_back(e); st_q1.push_back(st); end
      2: begin exp_q2.push_back(e); st_q2.push_back(st); end
      default: begin exp_q3.push_back(e); st_q3.push_back(st); end
    endcase
  endtask

  // Drive one frame on line idx; the line is left at the stop level afterwards
  task automatic send(input int idx, input logic [15:0] data, input bit flip, input logic stop_val);
    int          wd;
    int          pm;
    logic [15:0] m;
    logic        pbit;
    logic        pe_exp;
    wd = wd_of[idx];
    pm = pm_of[idx];
    m = 16'(32'(data) & ((32'd1 << wd) - 32'd1));
    pbit = (pm == 2) ? ~(^m) : (^m);
    if (flip) pbit = ~pbit;
    if (pm == 0) pe_exp = 1'b0;
    else if (pm == 1) pe_exp = ((^{m, pbit}) != 1'b0);
    else pe_exp = ((^{m, pbit}) != 1'b1);
    push_exp(idx, {~stop_val, pe_exp, m}, cyc);
    lines[idx] = 1'b0;
    idle(BIT);
    for (int i = 0; i < wd; i++) begin
      lines[idx] = m[i];
      idle(BIT);
    end
    if (pm != 0) begin
      lines[idx] = pbit;
      idle(BIT);
    end
    lines[idx] = stop_val;
    idle(BIT);
  endtask

  task automatic check_zero(input int idx, input logic [18:0] got);
    total++;
    assert (got === 19'd0) else begin
      bad++;
      $error("FAIL reset_outputs inst=%0d got=%h want=0", idx, got);
    end
  endtask

  // Per-instance completion check: pulse width, expected frame and latency
  task automatic mon(input int idx, input logic d, input logic dp,
                     input logic [15:0] data, input logic pe, input logic fe);
    logic [17:0] e;
    int          s;
    int          lat;
    int          want;
    bit          have;
    if (!d) return;
    total++;
    assert (!dp) else begin
      bad++;
      $error("FAIL done_width inst=%0d got=2+ cycles want=1", idx);
    end
    have = 1'b0;
    e = '0;
    s = 0;
    case (idx)
      0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); s = st_q0.pop_front(); have = 1'b1; end
      1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); s = st_q1.pop_front(); have = 1'b1; end
      2: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); s = st_q2.pop_front(); have = 1'b1; end
      default: if (exp_q3.size() > 0) begin e = exp_q3.pop_front(); s = st_q3.pop_front(); have = 1'b1; end
    endcase
    total++;
    assert (have) else begin
      bad++;
      $error("FAIL unexpected_done inst=%0d got=rx_done want=none", idx);
    end
    if (have) begin
      total++;
      assert ({fe, pe, data} === e) else begin
        bad++;
        $error("FAIL frame inst=%0d got fe=%b pe=%b data=%h want fe=%b pe=%b data=%h",
               idx, fe, pe, data, e[17], e[16], e[15:0]);
      end
      lat = cyc - s;
      want = 17 + BIT * (wd_of[idx] + ((pm_of[idx] != 0) ? 1 : 0));
      total++;
      assert ((lat >= want - 2) && (lat <= want + 2)) else begin
        bad++;
        $error("FAIL latency inst=%0d got=%0d want=%0d+/-2", idx, lat, want);
      end
    end
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done = 4'b0000;
    end else begin
      mon(0, done0, prev_done[0], 16'(data0), pe0, fe0);
      mon(1, done1, prev_done[1], 16'(data1), pe1, fe1);
      mon(2, done2, prev_done[2], 16'(data2), pe2, fe2);
      mon(3, done3, prev_done[3], 16'(data3), pe3, fe3);
      prev_done = {done3, done2, done1, done0};
    end
  end

  initial begin
    int   idx;
    int   wait_cnt;
    logic stop_v;

    // Reset values
    rst_n = 1'b0;
    #12;
    check_zero(0, {done0, 11'(data0), pe0, fe0, 4'b0});
    check_zero(1, {done1, 11'(data1), pe1, fe1, 4'b0});
    check_zero(2, {done2, 11'(data2), pe2, fe2, 4'b0});
    check_zero(3, {done3, 11'(data3), pe3, fe3, 4'b0});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);

    // 6-bit frame, no parity
    send(2, 16'b101011, 1'b0, 1'b1);
    idle(20);

    // Back-to-back 8-bit frames
    send(0, 16'h2B, 1'b0, 1'b1);
    send(0, 16'h35, 1'b0, 1'b1);
    idle(20);

    // Short glitch rejected, then a real frame
    lines[0] = 1'b0;
    idle(3);
    lines[0] = 1'b1;
    idle(30);
    send(0, 16'hA5, 1'b0, 1'b1);
    idle(20);

    // Even parity: wrong bit then correct bit
    send(1, 16'h01, 1'b1, 1'b1);
    send(1, 16'h03, 1'b0, 1'b1);
    idle(20);

    // Odd parity: correct then wrong
    send(3, 16'h13, 1'b0, 1'b1);
    send(3, 16'h13, 1'b1, 1'b1);
    idle(20);

    // Framing error followed by a break, then recovery
    send(0, 16'h5A, 1'b0, 1'b0);
    idle(50);
    lines[0] = 1'b1;
    idle(30);
    send(0, 16'hC3, 1'b0, 1'b1);
    idle(20);

    // Reset in the middle of 8'hFF aborts silently
    lines[0] = 1'b0;
    idle(BIT);
    lines[0] = 1'b1;
    idle(4 * BIT);
    rst_n = 1'b0;
    #1;
    check_zero(0, {done0, 11'(data0), pe0, fe0, 4'b0});
    check_zero(1, {done1, 11'(data1), pe1, fe1, 4'b0});
    check_zero(3, {done3, 11'(data3), pe3, fe3, 4'b0});
    idle(2);
    rst_n = 1'b1;
    idle(6 * BIT);
    send(0, 16'h3C, 1'b0, 1'b1);
    idle(20);

    // Random frames across all receivers
    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 3);
      stop_v = ($urandom_range(0, 7) != 0);
      send(idx, 16'($urandom), ($urandom_range(0, 3) == 0), stop_v);
      if (!stop_v) begin
        idle($urandom_range(0, 3) * BIT);
        lines[idx] = 1'b1;
        idle(BIT);
      end
      idle($urandom_range(0, 12));
    end

    // Drain outstanding frames, bounded
    wait_cnt = 0;
    while (((exp_q0.size() + exp_q1.size() + exp_q2.size() + exp_q3.size()) != 0) && (wait_cnt < 400)) begin
      idle(1);
      wait_cnt++;
    end
    idle(5);
    total++;
    assert ((exp_q0.size() + exp_q1.size() + exp_q2.size() + exp_q3.size()) == 0) else begin
      bad++;
      $error("FAIL missing_done got=%0d pending want=0",
             exp_q0.size() + exp_q1.size() + exp_q2.size() + exp_q3.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
